// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    CSUM    = 2'd3
  } sched_state_t;

  localparam logic [7:0] HDR_BASE_DEF = 8'hA0;

  // Bytes on the wire per packet: header + payload + checksum.
  function automatic int unsigned pkt_len(input int unsigned payload_len);
    return payload_len + 2;
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester/UART-FIFO bundle between game-state producers and the TX scheduler.
interface uart_tx_sched_if #(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned PAYLOAD_LEN = 2
);
  logic [N_REQ-1:0]               req;
  logic [N_REQ*PAYLOAD_LEN*8-1:0] req_data;
  logic [N_REQ-1:0]               gnt;
  logic                           tx_full;
  logic                           wr_uart;
  logic [7:0]                     w_data;
  logic                           busy;

  modport master (output req, req_data, tx_full, input gnt, wr_uart, w_data, busy);
  modport slave  (input req, req_data, tx_full, output gnt, wr_uart, w_data, busy);
endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     win,
  output logic [PTR_W-1:0] win_id
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic           found;
  int unsigned    offset;
  int unsigned    sum;

  assign dbl = {req, req};
  assign rot = N'(dbl >> ptr);

  // Rotate so bit 0 is the pointer position, then take the lowest set bit.
  always_comb begin
    found  = 1'b0;
    offset = 0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found  = 1'b1;
        offset = k;
      end
    end
    sum = 32'(ptr) + offset;
    if (sum >= N) sum = sum - N;
    win_id = PTR_W'(sum);
    win    = found ? (N'(1) << win_id) : '0;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin packetiser: header|id, payload bytes (MSB first), XOR checksum into the UART TX FIFO.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned PAYLOAD_LEN = 2,
  parameter logic [7:0]  HDR_BASE    = HDR_BASE_DEF
) (
  input logic           clk,
  input logic           rst,
  uart_tx_sched_if.slave bus
);

  localparam int unsigned PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned IDX_W   = $clog2(PAYLOAD_LEN) + 1;
  localparam int unsigned SLICE_W = PAYLOAD_LEN * 8;

  sched_state_t       state, state_d;
  logic [PTR_W-1:0]   ptr, ptr_d;
  logic [N_REQ-1:0]   gnt_d;
  logic [SLICE_W-1:0] shadow, shadow_d;
  logic [7:0]         csum, csum_d;
  logic [7:0]         w_data_d;
  logic [IDX_W-1:0]   idx, idx_d;
  logic [IDX_W-1:0]   sel;
  logic [7:0]         next_byte;
  logic [7:0]         hdr;
  logic               busy_d;
  logic               write;
  logic [N_REQ-1:0]   win;
  logic [PTR_W-1:0]   win_id;

  rr_arbiter #(.N(N_REQ), .PTR_W(PTR_W)) u_arb (
    .req    (bus.req),
    .ptr    (ptr),
    .win    (win),
    .win_id (win_id)
  );

  assign write       = (state != IDLE) && !bus.tx_full;
  assign bus.wr_uart = write;
  assign hdr         = HDR_BASE | 8'(win_id);

  // Byte that w_data must present after the current write.
  always_comb begin
    sel       = (state == HDR) ? '0 : IDX_W'(idx + 1'b1);
    next_byte = '0;
    for (int unsigned k = 0; k < PAYLOAD_LEN; k++) begin
      if (sel == IDX_W'(k)) next_byte = shadow[(PAYLOAD_LEN-1-k)*8 +: 8];
    end
  end

  // Next-state and datapath updates; w_data is preloaded so it stays stable under stall.
  always_comb begin
    state_d  = state;
    ptr_d    = ptr;
    gnt_d    = '0;
    shadow_d = shadow;
    csum_d   = csum;
    idx_d    = idx;
    w_data_d = bus.w_data;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          gnt_d    = win;
          shadow_d = SLICE_W'(bus.req_data >> (32'(win_id) * SLICE_W));
          csum_d   = hdr;
          w_data_d = hdr;
          idx_d    = '0;
          ptr_d    = (win_id == PTR_W'(N_REQ - 1)) ? '0 : PTR_W'(win_id + 1'b1);
          state_d  = HDR;
        end
      end
      HDR: begin
        if (write) begin
          w_data_d = next_byte;
          state_d  = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (write) begin
          csum_d = csum ^ bus.w_data;
          idx_d  = IDX_W'(idx + 1'b1);
          if (idx == IDX_W'(PAYLOAD_LEN - 1)) begin
            w_data_d = csum ^ bus.w_data;
            state_d  = CSUM;
          end else begin
            w_data_d = next_byte;
          end
        end
      end
      CSUM: begin
        if (write) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      ptr        <= '0;
      shadow     <= '0;
      csum       <= '0;
      idx        <= '0;
      bus.gnt    <= '0;
      bus.w_data <= 8'h00;
      bus.busy   <= 1'b0;
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      shadow     <= shadow_d;
      csum       <= csum_d;
      idx        <= idx_d;
      bus.gnt    <= gnt_d;
      bus.w_data <= w_data_d;
      bus.busy   <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed vectors, corner sequences and a randomized packet-level model.
module tb_uart_tx_sched;
  import uart_sched_pkg::*;

  localparam int unsigned N  = 2;
  localparam int unsigned PL = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_sched_if #(.N_REQ(N), .PAYLOAD_LEN(PL)) bus ();

  uart_tx_sched #(.N_REQ(N), .PAYLOAD_LEN(PL), .HDR_BASE(8'hA0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the sample point of the next cycle.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  typedef struct {
    logic [1:0]      req;
    logic [15:0]     d0;
    logic [15:0]     d1;
    int              stall;
    logic [3:0][7:0] exp;
  } vec_t;

  vec_t vecs[6];

  // Single-requester packet with an optional stall right after the header.
  task automatic run_vec(input int vi, input vec_t v);
    int n, cnt, got, last, stalled;
    string tag;
    tag = $sformatf("vec%0d", vi);
    bus.req_data = {v.d1, v.d0};
    bus.tx_full  = 1'b0;
    bus.req      = v.req;
    n = 0;
    do begin cyc(); n++; end while (bus.gnt == '0 && n < 20);
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'(v.req));
    bus.req = '0;
    got = 0; last = -1; stalled = 0; cnt = 0;
    while (got < 4 && cnt < 40) begin
      bus.tx_full = (got == 1 && stalled < v.stall);
      #1;
      if (bus.tx_full) begin
        stalled++;
        chk({tag, "_stall_wr"}, 32'(bus.wr_uart), 32'd0);
        chk({tag, "_stall_hold"}, 32'(bus.w_data), 32'(v.exp[2]));
      end else begin
        chk({tag, "_wr"}, 32'(bus.wr_uart), 32'd1);
        chk({tag, $sformatf("_byte%0d", got)}, 32'(bus.w_data), 32'(v.exp[3-got]));
        got++;
        last = cnt;
      end
      cyc();
      cnt++;
    end
    bus.tx_full = 1'b0;
    chk({tag, "_count"}, 32'(got), 32'd4);
    chk({tag, "_latency"}, 32'(last), 32'(pkt_len(PL) - 1 + v.stall));
    chk({tag, "_busy_fall"}, 32'(bus.busy), 32'd0);
  endtask

  logic [7:0] bytes[$];
  int         gids[$];

  // Record written bytes and grant ids; requesters optionally drop on grant, payload optionally scrambled.
  task automatic collect(input int nbytes, input bit drop, input bit scramble);
    int cnt;
    bytes.delete();
    gids.delete();
    cnt = 0;
    while (bytes.size() < nbytes && cnt < 80) begin
      #1;
      if (bus.gnt != '0) begin
        for (int i = 0; i < N; i++) if (bus.gnt[i]) gids.push_back(i);
        if (drop) bus.req = bus.req & ~bus.gnt;
        if (scramble) bus.req_data = '1;
      end
      if (bus.wr_uart) bytes.push_back(bus.w_data);
      cyc();
      cnt++;
    end
  endtask

  task automatic cmp_bytes(input string name, input logic [7:0] e[$]);
    chk({name, "_len"}, 32'(bytes.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < bytes.size(); i++)
      chk($sformatf("%s_b%0d", name, i), 32'(bytes[i]), 32'(e[i]));
  endtask

  // Packet-level reference: queue of bytes still owed by the packet in flight.
  logic [7:0]   m_q[$];
  logic [N-1:0] m_gnt;
  int unsigned  m_ptr;
  bit           m_zero;
  logic [N-1:0] pend;

  task automatic model_edge();
    int unsigned w;
    bit          f;
    logic [15:0] slice;
    logic [7:0]  b, cs;
    if (!rst) begin
      m_q.delete();
      m_gnt  = '0;
      m_ptr  = 0;
      m_zero = 1'b1;
      return;
    end
    m_gnt = '0;
    if (m_q.size() != 0) begin
      if (!bus.tx_full) void'(m_q.pop_front());
    end else if (bus.req != '0) begin
      f = 1'b0; w = 0;
      for (int unsigned k = 0; k < N; k++)
        if (!f && bus.req[(m_ptr + k) % N]) begin f = 1'b1; w = (m_ptr + k) % N; end
      m_gnt[w] = 1'b1;
      cs = 8'hA0 + 8'(w);
      m_q.push_back(cs);
      slice = 16'(bus.req_data >> (w * PL * 8));
      for (int unsigned k = 0; k < PL; k++) begin
        b = 8'(slice >> (8 * (PL - 1 - k)));
        m_q.push_back(b);
        cs = cs ^ b;
      end
      m_q.push_back(cs);
      m_ptr  = (w + 1) % N;
      m_zero = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: timeout, simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] e[$];
    vecs[0] = '{req: 2'b01, d0: 16'h1234, d1: 16'h0000, stall: 0, exp: 32'hA0123486};
    vecs[1] = '{req: 2'b10, d0: 16'h0000, d1: 16'hBEEF, stall: 0, exp: 32'hA1BEEFF0};
    vecs[2] = '{req: 2'b01, d0: 16'h1234, d1: 16'h5555, stall: 5, exp: 32'hA0123486};
    vecs[3] = '{req: 2'b10, d0: 16'h7777, d1: 16'h0000, stall: 0, exp: 32'hA10000A1};
    vecs[4] = '{req: 2'b01, d0: 16'hFFFF, d1: 16'h0000, stall: 0, exp: 32'hA0FFFFA0};
    vecs[5] = '{req: 2'b10, d0: 16'h0000, d1: 16'hBEEF, stall: 2, exp: 32'hA1BEEFF0};

    bus.req = '0; bus.req_data = '0; bus.tx_full = 1'b0;
    do_reset();
    #1;
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_wr", 32'(bus.wr_uart), 32'd0);
    chk("rst_wdata", 32'(bus.w_data), 32'd0);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Simultaneous requests after reset: requester 0 first.
    do_reset();
    bus.req_data = {16'hBEEF, 16'h1234};
    bus.req = 2'b11;
    collect(8, 1'b1, 1'b0);
    e = '{8'hA0, 8'h12, 8'h34, 8'h86, 8'hA1, 8'hBE, 8'hEF, 8'hF0};
    cmp_bytes("both", e);
    chk("both_ngnt", 32'(gids.size()), 32'd2);
    if (gids.size() == 2) begin
      chk("both_g0", 32'(gids[0]), 32'd0);
      chk("both_g1", 32'(gids[1]), 32'd1);
    end

    // Held requests alternate fairly.
    bus.req = 2'b11;
    collect(16, 1'b0, 1'b0);
    bus.req = '0;
    chk("rr_nbytes", 32'(bytes.size()), 32'd16);
    chk("rr_ngnt", 32'(gids.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < gids.size()) chk($sformatf("rr_g%0d", i), 32'(gids[i]), 32'(i % 2));
      if (4 * i < bytes.size()) chk($sformatf("rr_hdr%0d", i), 32'(bytes[4*i]), 32'(8'hA0 + 8'(i % 2)));
    end
    cyc();

    // Payload change after grant must not leak into the packet.
    bus.req_data = {16'hBEEF, 16'h1234};
    bus.req = 2'b01;
    collect(4, 1'b1, 1'b1);
    e = '{8'hA0, 8'h12, 8'h34, 8'h86};
    cmp_bytes("snap", e);
    cyc();

    // Reset mid-packet right after the first payload byte.
    do_reset();
    bus.req_data = {16'hBEEF, 16'h1234};
    bus.req = 2'b01;
    begin
      int n;
      n = 0;
      while (n < 20 && !(bus.wr_uart && bus.w_data == 8'h12)) begin
        if (bus.gnt != '0) bus.req = '0;
        cyc();
        n++;
      end
      chk("mid_reached", 32'(n < 20), 32'd1);
    end
    cyc();
    rst = 1'b0;
    bus.req = '0;
    cyc();
    #1;
    chk("mid_wr", 32'(bus.wr_uart), 32'd0);
    chk("mid_wdata", 32'(bus.w_data), 32'd0);
    chk("mid_busy", 32'(bus.busy), 32'd0);
    chk("mid_gnt", 32'(bus.gnt), 32'd0);
    rst = 1'b1;
    bus.req = 2'b10;
    collect(4, 1'b1, 1'b0);
    e = '{8'hA1, 8'hBE, 8'hEF, 8'hF0};
    cmp_bytes("mid_after", e);
    cyc();

    // Randomized traffic against the packet-level model.
    bus.req = '0;
    pend = '0;
    do_reset();
    m_q.delete(); m_gnt = '0; m_ptr = 0; m_zero = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      for (int i = 0; i < N; i++) begin
        if (m_gnt[i] && $urandom_range(0, 1) == 0) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(0, 2) == 0) pend[i] = 1'b1;
      end
      bus.req      = pend;
      bus.req_data = 32'($urandom);
      bus.tx_full  = ($urandom_range(0, 3) == 0);
      #1;
      chk("rnd_gnt", 32'(bus.gnt), 32'(m_gnt));
      chk("rnd_busy", 32'(bus.busy), 32'(m_q.size() != 0));
      chk("rnd_wr", 32'(bus.wr_uart), 32'(m_q.size() != 0 && !bus.tx_full));
      if (m_q.size() != 0) chk("rnd_wdata", 32'(bus.w_data), 32'(m_q[0]));
      else if (m_zero) chk("rnd_wdata_rst", 32'(bus.w_data), 32'd0);
      model_edge();
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
